// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory responder: FSM states, operation
// codes and the wait-state counter width.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH word storage: synchronous write, registered synchronous read.
// The read register is reset; the storage itself is not.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder with LATENCY wait states, stall and one-cycle ready.
// Build option: DMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; captures the request when seen
// BUSY  | counting down wait states; request inputs ignored
// RESP  | ready (and err) high for one cycle, then back to IDLE
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             stall,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW+1:0]    cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  op_t              cap_op;

  logic             req;
  logic             go_resp;
  op_t              c_op;
  logic [AW+1:0]    c_addr;
  logic [WIDTH-1:0] c_wdata;
  logic             mis;
  logic             we;
  logic             re;

  assign req   = mem_read | mem_write;
  assign stall = req & ~ready;

  // With LATENCY=1 the commit happens on the sampling edge, so the commit
  // path takes the live inputs in IDLE and the captured ones in BUSY.
  always_comb begin
    go_resp = 1'b0;
    c_op    = cap_op;
    c_addr  = cap_addr;
    c_wdata = cap_wdata;
    case (state)
      IDLE: begin
        go_resp = (LATENCY == 1) && req;
        c_op    = mem_write ? OP_WR : OP_RD;
        c_addr  = addr[AW+1:0];
        c_wdata = wdata;
      end
      BUSY:    go_resp = (cnt <= CNT_W'(1));
      default: go_resp = 1'b0;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (c_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
  logic unused_lsb;
  assign unused_lsb = ^c_addr[1:0];
`endif

  logic unused_upper;
  assign unused_upper = ^addr[WIDTH-1:AW+2];

  assign we = go_resp & (c_op == OP_WR) & ~mis;
  assign re = go_resp & (c_op == OP_RD) & ~mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_op    <= OP_RD;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready <= go_resp;
      err   <= go_resp & mis;
      case (state)
        IDLE: begin
          if (req) begin
            cap_addr  <= addr[AW+1:0];
            cap_wdata <= wdata;
            cap_op    <= mem_write ? OP_WR : OP_RD;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (go_resp) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (re),
    .addr  (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: three instances (LATENCY 2, 1, 4), directed
// table, reset-abort sequence and randomized traffic against a word-level model.
module tb_mips_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [31:0] rdata     [3];
  logic        ready     [3];
  logic        stall     [3];
  logic        err       [3];

  int lat_of [3] = '{2, 1, 4};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    mips_dmem_responder #(.WIDTH(32), .DEPTH(64), .LATENCY(L)) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .rdata     (rdata[g]),
      .ready     (ready[g]),
      .stall     (stall[g]),
      .err       (err[g])
    );
  end

  // word-level reference model
  logic [31:0] mdl    [3][64];
  bit          kn     [3][64];
  logic [31:0] mrd    [3];
  bit          mrd_k  [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] e, output bit ek,
                       output bit e_err);
    int w;
    bit m;
    w = int'((a >> 2) % 64);
    m = ALIGN && (a[1:0] != 2'b00);
    if (wr) begin
      if (!m) begin
        mdl[d][w] = wd;
        kn[d][w]  = 1'b1;
      end
    end else if (rd && !m) begin
      mrd[d]   = mdl[d][w];
      mrd_k[d] = kn[d][w];
    end
    e     = mrd[d];
    ek    = mrd_k[d];
    e_err = m;
  endtask

  task automatic clear_in(input int d);
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    addr[d]      = '0;
    wdata[d]     = '0;
  endtask

  // Called just after a rising edge; leaves the DUT idle just after a rising edge.
  task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit drop, input logic [31:0] e_rd,
                     input bit c_rd, input bit e_err);
    int cyc;
    bit got;
    mem_read[d]  = rd;
    mem_write[d] = wr;
    addr[d]      = a;
    wdata[d]     = wd;
    #1;
    chk("stall_pre", 32'(stall[d]), 32'(1));
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ready[d]) begin
        got = 1'b1;
      end else begin
        if (drop) clear_in(d);
        #1;
        chk("stall_busy", 32'(stall[d]), drop ? 32'(0) : 32'(1));
        chk("err_busy", 32'(err[d]), 32'(0));
      end
    end
    if (!got) begin
      chk("ready_timeout", 32'(0), 32'(1));
    end else begin
      chk("latency", 32'(cyc), 32'(lat_of[d]));
      chk("stall_ready", 32'(stall[d]), 32'(0));
      chk("err_ready", 32'(err[d]), 32'(e_err));
      if (c_rd) chk("rdata", rdata[d], e_rd);
    end
    @(posedge clk);
    #1;
    clear_in(d);
    #1;
    chk("ready_pulse", 32'(ready[d]), 32'(0));
    chk("err_after", 32'(err[d]), 32'(0));
    chk("stall_idle", 32'(stall[d]), 32'(0));
    if (c_rd) chk("rdata_hold", rdata[d], e_rd);
  endtask

  typedef struct {
    int          d;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] e_rd;
    bit          e_err;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [31:0] e;
    bit          ek;
    bit          ee;

    vt[0]  = '{0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1, 1'b0, 1'b1, 32'h0,   32'h11111111, 32'h0,        1'b0};
    vt[3]  = '{1, 1'b0, 1'b1, 32'h4,   32'h22222222, 32'h0,        1'b0};
    vt[4]  = '{1, 1'b1, 1'b0, 32'h0,   32'h0,        32'h11111111, 1'b0};
    vt[5]  = '{1, 1'b1, 1'b0, 32'h4,   32'h0,        32'h22222222, 1'b0};
    vt[6]  = '{1, 1'b1, 1'b1, 32'h8,   32'hA5A5A5A5, 32'h22222222, 1'b0};
    vt[7]  = '{1, 1'b1, 1'b0, 32'h8,   32'h0,        32'hA5A5A5A5, 1'b0};
    vt[8]  = '{0, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vt[9]  = '{0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0};
    vt[10] = '{0, 1'b0, 1'b1, 32'h20,  32'h55555555, 32'h12345678, 1'b0};
    vt[11] = '{0, 1'b0, 1'b1, 32'h22,  32'h66666666, 32'h12345678, ALIGN};
    vt[12] = '{0, 1'b1, 1'b0, 32'h20,  32'h0, ALIGN ? 32'h55555555 : 32'h66666666, 1'b0};
    vt[13] = '{1, 1'b0, 1'b1, 32'h2,   32'h77777777, 32'hA5A5A5A5, ALIGN};
    vt[14] = '{1, 1'b1, 1'b0, 32'h0,   32'h0, ALIGN ? 32'h11111111 : 32'h77777777, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      clear_in(d);
      mrd[d]   = '0;
      mrd_k[d] = 1'b1;
      for (int w = 0; w < 64; w++) begin
        mdl[d][w] = '0;
        kn[d][w]  = 1'b0;
      end
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(ready[d]), 32'(0));
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_err", 32'(err[d]), 32'(0));
      chk("rst_stall", 32'(stall[d]), 32'(0));
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      model(vt[i].d, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, e, ek, ee);
      txn(vt[i].d, vt[i].rd, vt[i].wr, vt[i].a, vt[i].wd, 1'b0, vt[i].e_rd, 1'b1, vt[i].e_err);
    end

    // reset during the second BUSY cycle aborts the write
    model(2, 1'b0, 1'b1, 32'h20, 32'h0BADBEEF, e, ek, ee);
    txn(2, 1'b0, 1'b1, 32'h20, 32'h0BADBEEF, 1'b0, 32'h0, 1'b1, 1'b0);
    mem_write[2] = 1'b1;
    addr[2]      = 32'h20;
    wdata[2]     = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    #1;
    chk("abort_ready", 32'(ready[2]), 32'(0));
    chk("abort_rdata", rdata[2], 32'h0);
    chk("abort_stall_req", 32'(stall[2]), 32'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("abort_ready_hold", 32'(ready[2]), 32'(0));
    clear_in(2);
    #1;
    chk("abort_stall_noreq", 32'(stall[2]), 32'(0));
    @(negedge clk);
    rst[2] = 1'b0;
    mrd[2] = '0;
    mrd_k[2] = 1'b1;
    @(posedge clk);
    #1;
    model(2, 1'b1, 1'b0, 32'h20, 32'h0, e, ek, ee);
    txn(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BADBEEF, 1'b1, 1'b0);

    // randomized traffic
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        logic [31:0] wd;
        int          op;
        bit          rd;
        bit          wr;
        bit          drop;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        a = ($urandom & 32'h0000_0F00) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
        wd   = $urandom;
        op   = $urandom_range(0, 3);
        rd   = (op == 0) || (op == 2) || (op == 3);
        wr   = (op == 1) || (op == 2);
        drop = ($urandom_range(0, 4) == 0);
        model(d, rd, wr, a, wd, e, ek, ee);
        txn(d, rd, wr, a, wd, drop, e, ek, ee);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
